// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage access controller: bus widths,
// FSM state encodings and the watchdog limit.
package mem_access_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WD_W   = 8;

  // A WAIT that reaches this many cycles without mem_done is treated as a hung memory.
  localparam logic [WD_W-1:0] WD_LIMIT = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus between the access controller (master) and the memory (slave).
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_stall;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done, mem_stall
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done, mem_stall
  );

endinterface

// File: rtl/dff.sv
// Generic register cell with synchronous active-high reset to zero and load enable.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over load; otherwise capture d only when enabled.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mem_access_ctrl_wd_counter.sv
// Watchdog for the WAIT state: cleared when a request is issued, counts each
// WAIT cycle and flags the cycle whose increment reaches WD_LIMIT.
module wd_counter
  import mem_access_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WD_W-1:0] count;

  // Saturating count so a stale value can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != WD_LIMIT))
      count <= count + 8'd1;
  end

  // High in the WAIT cycle that brings the count up to the limit.
  assign tc = enable && (count == (WD_LIMIT - 8'd1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns an EX/MEM load/store into a single
// request pulse, freezes the pipeline while the memory works, captures load
// data and falls into a terminal error state if the memory never answers.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Mem_en,
  input  logic                 Mem_read,
  input  logic                 Mem_write,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W-1:0]    write_data,
  input  logic                 flush,
  mem_access_ctrl_if.master    bus,
  output logic [DATA_W-1:0]    data_read,
  output logic                 stall_pipe,
  output logic                 mem_misalign,
  output logic                 err
);

  localparam int REQ_W = 1 + ADDR_W + DATA_W;

  logic             access;
  logic             aligned_access;
  logic             req_now;
  logic             req_fire;
  logic             stall_c;
  logic             in_wait;
  logic             wd_tc;
  logic             load_rdata;
  logic [1:0]       state_bits;
  state_t           state_q;
  state_t           state_d;
  logic [REQ_W-1:0] req_q;
  logic             req_wr_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;

  assign access         = Mem_en && (Mem_read || Mem_write) && !flush;
  assign aligned_access = access && !address[0];
  assign mem_misalign   = access && address[0];

  dff #(.WIDTH(2)) state_reg (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (state_d),
    .q   (state_bits)
  );
  assign state_q = state_t'(state_bits);

  // Next-state and stall/request decode; only IDLE looks at the pipeline inputs,
  // so flush and mem_done during the request cycle are naturally ignored.
  always_comb begin
    state_d = state_q;
    req_now = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aligned_access) begin
          stall_c = 1'b1;
          if (!bus.mem_stall) begin
            req_now = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (bus.mem_done)
          state_d = ST_DONE;
        else if (wd_tc)
          state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset overrides everything, including an access presented while rst is high.
  assign req_fire   = req_now && !rst;
  assign stall_pipe = stall_c && !rst;
  assign in_wait    = (state_q == ST_WAIT);
  assign err        = (state_q == ST_ERR);

  dff #(.WIDTH(REQ_W)) req_reg (
    .clk (clk),
    .rst (rst),
    .en  (req_fire),
    .d   ({Mem_write, address, write_data}),
    .q   (req_q)
  );
  assign {req_wr_q, req_addr_q, req_wdata_q} = req_q;

  // Fields follow the pipeline during the request cycle and are held from the register afterwards.
  assign bus.mem_req   = req_fire;
  assign bus.mem_wr    = req_fire ? Mem_write  : req_wr_q;
  assign bus.mem_addr  = req_fire ? address    : req_addr_q;
  assign bus.mem_wdata = req_fire ? write_data : req_wdata_q;

  assign load_rdata = in_wait && bus.mem_done && !req_wr_q;

  dff #(.WIDTH(DATA_W)) data_reg (
    .clk (clk),
    .rst (rst),
    .en  (load_rdata),
    .d   (bus.mem_rdata),
    .q   (data_read)
  );

  wd_counter wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (req_fire),
    .enable (in_wait),
    .tc     (wd_tc)
  );

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Mem_en, input, 1, memory stage enable from the EX/MEM register.
REQ-005 SHALL have ports Mem_read and Mem_write, input, 1 each, access type; both high is treated as a write.
REQ-006 SHALL have port address, input, 16, byte address of the access.
REQ-007 SHALL have port write_data, input, 16, store data.
REQ-008 SHALL have port flush, input, 1, squash of the presented instruction.
REQ-009 SHALL have ports mem_req and mem_wr, output, 1 each, memory request pulse and write qualifier.
REQ-010 SHALL have ports mem_addr and mem_wdata, output, 16 each, memory address and memory write data.
REQ-011 SHALL have ports mem_rdata (input, 16, read data), mem_done (input, 1, completion) and mem_stall (input, 1, memory cannot accept a request).
REQ-012 SHALL have port data_read, output, 16, registered load result fed to the MEM/WB register.
REQ-013 SHALL have ports stall_pipe, mem_misalign and err, output, 1 each: pipeline freeze, misaligned access and sticky timeout error.

Function
REQ-014 SHALL define an access as Mem_en and (Mem_read or Mem_write) and not flush.
REQ-015 SHALL flag an access with address[0]=1 as misaligned: mem_misalign=1 combinationally, no request issued, stall_pipe=0.
REQ-016 SHALL implement the states IDLE, WAIT, DONE and ERR.
REQ-017 IDLE with an aligned access SHALL drive stall_pipe=1.
REQ-018 IDLE with an aligned access and mem_stall=1 SHALL keep mem_req=0 and remain in IDLE.
REQ-019 IDLE with an aligned access and mem_stall=0 SHALL pulse mem_req=1 for exactly one cycle, with mem_wr=Mem_write, mem_addr=address and mem_wdata=write_data, and go to WAIT.
REQ-020 WAIT SHALL drive stall_pipe=1 and mem_req=0, hold mem_addr, mem_wr and mem_wdata stable, and ignore flush.
REQ-021 WAIT SHALL sample mem_done from the first cycle after the request; mem_done in the request cycle SHALL be ignored.
REQ-022 On mem_done in WAIT, the block SHALL load mem_rdata into data_read for reads, leave data_read unchanged for writes, and go to DONE.
REQ-023 DONE SHALL drive stall_pipe=0 for one cycle, issue no request, and go to IDLE.
REQ-024 The minimum access SHALL be 3 cycles, i.e. 2 stall cycles.
REQ-025 An 8-bit watchdog SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-026 When the watchdog reaches 255 without mem_done, the block SHALL go to ERR.
REQ-027 ERR SHALL be terminal until rst, with err=1, stall_pipe=0 and mem_req=0.
REQ-028 Non-access cycles (including flush in IDLE) SHALL drive stall_pipe=0 and mem_req=0, and keep data_read held.
REQ-029 If mem_done arrives in the same cycle the watchdog reaches 255, completion SHALL win: go to DONE, not ERR.

Reset
REQ-030 rst SHALL force state=IDLE, data_read=0, watchdog=0, err=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0 and stall_pipe=0 on the next edge.
REQ-031 rst SHALL take priority over every other input, including rst asserted mid-WAIT; late mem_done after reset SHALL be ignored in IDLE.

Structure
REQ-032 A shared package SHALL hold the state encodings (2-bit) and the constant WD_LIMIT=255.
REQ-033 State, data_read and request-field registers SHALL be built from the codebase dff cell.
REQ-034 The watchdog SHALL be one sub-module, wd_counter: 8-bit, with clear, enable and terminal-count output.

Verification
REQ-035 Read at 0x0010, mem_stall=0, mem_done one cycle after mem_req, mem_rdata=0xBEEF -> mem_req pulses once, stall_pipe high 2 cycles, data_read=0xBEEF in DONE.
REQ-036 Write at 0x0020, data 0x1234, mem_stall=1 for 3 cycles -> no mem_req for 3 cycles, then one mem_req with mem_wr=1 and mem_wdata=0x1234; data_read unchanged.
REQ-037 Read at 0x0011 -> mem_misalign=1, mem_req=0, stall_pipe=0 in the same cycle.
REQ-038 Read issued and mem_done never asserted -> err=1 after 255 WAIT cycles, stall_pipe=0; no further mem_req until rst.
REQ-039 rst asserted in the 2nd WAIT cycle, mem_done one cycle later -> state IDLE, all outputs 0, data_read stays 0x0000.
